// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: sequences program load, bounded run, and register/memory dump for the MIPS pipeline.
module proc_run_ctrl #(
  parameter int PROG_LEN   = 13,
  parameter int RUN_CYCLES = 45,
  parameter int NUM_REGS   = 32,
  parameter int MEM_BYTES  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  output logic [4:0]  progIdx,
  input  logic [31:0] progData,
  output logic        initializing,
  output logic        ending,
  output logic        instrWrite,
  output logic        instrRead,
  output logic [31:0] instrIn,
  output logic [31:0] initInstrAddr,
  output logic        pcReset,
  output logic        pcWrite,
  output logic [15:0] cycleNo,
  output logic [4:0]  endReadReg1,
  output logic [4:0]  endReadReg2,
  output logic [31:0] endMemAddr,
  output logic        regDumpValid,
  output logic        memDumpValid,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP_REG, DUMP_MEM, DONE} state_e;
  state_e r_state, w_next;
  logic [4:0]  r_idx;
  logic [15:0] r_cycle;
  logic [3:0]  r_pair;
  logic [15:0] r_mem;
  logic w_last_idx, w_last_run, w_last_pair, w_last_mem;
  assign w_last_idx  = r_idx == 5'(PROG_LEN - 1);
  assign w_last_run  = r_cycle == 16'(RUN_CYCLES - 1);
  assign w_last_pair = r_pair == 4'(NUM_REGS / 2 - 1);
  assign w_last_mem  = r_mem == 16'(MEM_BYTES - 1);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = start ? LOAD : IDLE;
      LOAD:     w_next = w_last_idx ? RUN : LOAD;
      RUN:      w_next = (halt || w_last_run) ? DUMP_REG : RUN;
      DUMP_REG: w_next = w_last_pair ? DUMP_MEM : DUMP_REG;
      DUMP_MEM: w_next = w_last_mem ? DONE : DUMP_MEM;
      DONE:     w_next = start ? LOAD : DONE;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cycle <= '0;
      r_pair  <= '0;
      r_mem   <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= (r_state == LOAD) ? r_idx + 5'd1 : '0;
      r_cycle <= (w_next == LOAD) ? '0 : (r_state == RUN && w_next == RUN) ? r_cycle + 16'd1 : r_cycle;
      r_pair  <= (r_state == DUMP_REG) ? r_pair + 4'd1 : '0;
      r_mem   <= (r_state == DUMP_MEM && w_next == DUMP_MEM) ? r_mem + 16'd1 : (w_next == DUMP_MEM) ? '0 : r_mem;
    end
  end
  assign progIdx       = r_idx;
  assign initInstrAddr = {25'b0, r_idx, 2'b00};
  assign instrIn       = progData;
  assign initializing  = r_state == LOAD;
  assign instrWrite    = r_state == LOAD;
  assign pcReset       = r_state == IDLE || r_state == LOAD;
  assign pcWrite       = r_state == RUN;
  assign instrRead     = r_state == RUN || r_state == DUMP_REG;
  assign ending        = r_state == DUMP_REG || r_state == DUMP_MEM || r_state == DONE;
  assign regDumpValid  = r_state == DUMP_REG;
  assign memDumpValid  = r_state == DUMP_MEM;
  assign busy          = r_state != IDLE && r_state != DONE;
  assign done          = r_state == DONE;
  assign cycleNo       = r_cycle;
  // Register ports read zero outside the dump so IDLE shows all-zero addresses.
  assign endReadReg1   = regDumpValid ? {r_pair, 1'b0} : '0;
  assign endReadReg2   = regDumpValid ? {r_pair, 1'b1} : '0;
  assign endMemAddr    = {16'b0, r_mem};
endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb_proc_run_ctrl: randomized scoreboard bench; a phase-level model queues expected outputs per cycle.
module tb_proc_run_ctrl;
  localparam int PL = 13, RC = 45, NR = 32, MB = 64;
  logic clk = 0, reset = 1, start = 0, halt = 0;
  logic [31:0] progData = 0;
  logic [4:0]  progIdx, endReadReg1, endReadReg2;
  logic        initializing, ending, instrWrite, instrRead, pcReset, pcWrite;
  logic        regDumpValid, memDumpValid, busy, done;
  logic [31:0] instrIn, initInstrAddr, endMemAddr;
  logic [15:0] cycleNo;
  proc_run_ctrl #(.PROG_LEN(PL), .RUN_CYCLES(RC), .NUM_REGS(NR), .MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .progIdx(progIdx), .progData(progData),
    .initializing(initializing), .ending(ending), .instrWrite(instrWrite), .instrRead(instrRead),
    .instrIn(instrIn), .initInstrAddr(initInstrAddr), .pcReset(pcReset), .pcWrite(pcWrite),
    .cycleNo(cycleNo), .endReadReg1(endReadReg1), .endReadReg2(endReadReg2), .endMemAddr(endMemAddr),
    .regDumpValid(regDumpValid), .memDumpValid(memDumpValid), .busy(busy), .done(done));
  always #5 clk = ~clk;
  typedef enum {P_IDLE, P_LOAD, P_RUN, P_DREG, P_DMEM, P_DONE} ph_e;
  typedef struct packed {
    logic bsy, dn, pcr, pcw, init, endg, iw, ir, rdv, mdv;
    logic [4:0] pidx;
    logic [15:0] cyc;
    logic [4:0] r1, r2;
    logic [31:0] maddr;
  } obs_t;
  typedef struct {obs_t e; obs_t m; ph_e p; int k;} item_t;
  item_t q[$];
  int checks = 0, errors = 0, mc = 0;
  ph_e cur = P_IDLE;
  function automatic void expect_of(input ph_e p, input int k, input int c, output obs_t e, output obs_t m);
    e = '0;
    m = '1;
    case (p)
      P_IDLE: e.pcr = 1;
      P_LOAD: begin
        {e.bsy, e.pcr, e.init, e.iw} = '1;
        e.pidx = 5'(k);
        {m.r1, m.r2, m.maddr} = '0;
      end
      P_RUN: begin
        {e.bsy, e.pcw, e.ir} = '1;
        e.cyc = 16'(k);
        {m.pidx, m.r1, m.r2, m.maddr} = '0;
      end
      P_DREG: begin
        {e.bsy, e.endg, e.ir, e.rdv} = '1;
        e.cyc = 16'(c);
        e.r1 = 5'(2 * k);
        e.r2 = 5'(2 * k + 1);
        {m.pidx, m.maddr, m.pcr, m.init} = '0;
      end
      P_DMEM: begin
        {e.bsy, e.endg, e.mdv} = '1;
        e.cyc = 16'(c);
        e.maddr = 32'(k);
        {m.pidx, m.r1, m.r2, m.pcr, m.init, m.ir} = '0;
      end
      default: begin
        {e.dn, e.endg} = '1;
        e.cyc = 16'(c);
        e.maddr = 32'(MB - 1);
        {m.pidx, m.r1, m.r2, m.pcr, m.init, m.ir} = '0;
      end
    endcase
  endfunction
  task automatic step(input ph_e p, input int k, input bit st, input bit hl, input bit rs);
    item_t it;
    expect_of(p, k, mc, it.e, it.m);
    it.p = p;
    it.k = k;
    q.push_back(it);
    start = st;
    halt = hl;
    reset = rs;
    progData = $urandom;
    @(posedge clk);
    #1;
  endtask
  task automatic go(input int h, input int rs_at);
    step(cur, 0, 1, 0, 0);
    mc = 0;
    for (int k = 0; k < PL; k++) step(P_LOAD, k, 1'($urandom), 1'($urandom), 0);
    for (int c = 0; c < RC; c++) begin
      step(P_RUN, c, 1'($urandom), c == h, c == rs_at);
      if (c == rs_at) begin
        cur = P_IDLE;
        mc = 0;
        return;
      end
      mc = c;
      if (c == h) break;
    end
    for (int i = 0; i < NR / 2; i++) step(P_DREG, i, 1'($urandom), 1'($urandom), 0);
    for (int j = 0; j < MB; j++) step(P_DMEM, j, 1'($urandom), 1'($urandom), 0);
    for (int d = 0; d < 2; d++) step(P_DONE, 0, 0, 1'($urandom), 0);
    cur = P_DONE;
  endtask
  always @(negedge clk) begin
    obs_t a;
    item_t it;
    if (q.size() != 0) begin
      it = q.pop_front();
      a = {busy, done, pcReset, pcWrite, initializing, ending, instrWrite, instrRead, regDumpValid,
           memDumpValid, progIdx, cycleNo, endReadReg1, endReadReg2, endMemAddr};
      checks++;
      if (((a ^ it.e) & it.m) != '0) begin
        errors++;
        $display("FAIL %s k=%0d got=%h want=%h care=%h", it.p.name(), it.k, a, it.e, it.m);
      end
      checks++;
      if (instrIn !== progData) begin
        errors++;
        $display("FAIL instrIn got=%h want=%h", instrIn, progData);
      end
      checks++;
      if (initInstrAddr !== {25'b0, progIdx, 2'b00}) begin
        errors++;
        $display("FAIL initInstrAddr got=%h want=%h", initInstrAddr, {25'b0, progIdx, 2'b00});
      end
    end
  end
  initial begin
    @(posedge clk);
    #1;
    step(P_IDLE, 0, 1, 0, 1);
    reset = 0;
    go(99, -1);
    go(10, -1);
    go(RC - 1, -1);
    go(99, 20);
    go(99, -1);
    for (int n = 0; n < 6; n++) go(int'($urandom_range(0, 60)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 44)) : -1);
    step(cur, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
